// File: rtl/trsq_bus_fabric_if.sv
// CPU data-port and peripheral-slave bundle around trsq_bus_fabric.
// slave: the fabric's view; master: the CPU/peripheral side driving it.
interface trsq_bus_fabric_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_SLV = 3
);
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_wr_en;
  logic                      cpu_rd_en;
  logic                      cpu_stall;
  logic [DATA_W-1:0]         cpu_status;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV-1:0]        slv_wr_en;
  logic [NUM_SLV-1:0]        slv_rd_en;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [NUM_SLV-1:0]        slv_ready;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, cpu_status, slv_rdata, slv_ready,
    output cpu_rdata, cpu_stall, slv_addr, slv_wdata, slv_wr_en, slv_rd_en
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, cpu_status, slv_rdata, slv_ready,
    input  cpu_rdata, cpu_stall, slv_addr, slv_wdata, slv_wr_en, slv_rd_en
  );
endinterface

// File: rtl/trsq_bus_fabric.sv
// CPU data-port interconnect: RAM, NUM_SLV wait-state peripheral windows, fault/status regs.
// Optional macro FABRIC_TIMEOUT_EN enables the wait-state timeout abort.
module trsq_bus_fabric #(
  parameter int unsigned               ADDR_W        = 8,
  parameter int unsigned               DATA_W        = 8,
  parameter int unsigned               RAM_DEPTH     = 128,
  parameter int unsigned               NUM_SLV       = 3,
  parameter int unsigned               SLV_SPAN_LOG2 = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE      = {8'h90, 8'h84, 8'h80},
  parameter logic [ADDR_W-1:0]         ERR_ADDR      = 8'hFF,
  parameter int unsigned               TIMEOUT       = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  trsq_bus_fabric_if.slave bus,
  output logic             bus_err_irq
);

  localparam int unsigned      RAM_AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] FADDR_ADDR = ERR_ADDR - ADDR_W'(1);

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  logic access, wr_acc, rd_acc;
  assign access = bus.cpu_wr_en | bus.cpu_rd_en;
  assign wr_acc = bus.cpu_wr_en;
  assign rd_acc = bus.cpu_rd_en & ~bus.cpu_wr_en;

  // Address decode, priority RAM > slaves (lowest index) > ERR_ADDR > ERR_ADDR-1.
  logic               ram_sel, slv_any, err_sel, faddr_sel, unmapped;
  logic [NUM_SLV-1:0] slv_sel;

  always_comb begin
    ram_sel = 32'(bus.cpu_addr) < RAM_DEPTH;
    slv_sel = '0;
    slv_any = 1'b0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (!ram_sel && !slv_any &&
          ((bus.cpu_addr >> SLV_SPAN_LOG2) ==
           (SLV_BASE[i*ADDR_W +: ADDR_W] >> SLV_SPAN_LOG2))) begin
        slv_sel[i] = 1'b1;
        slv_any    = 1'b1;
      end
    end
    err_sel   = !ram_sel && !slv_any && (bus.cpu_addr == ERR_ADDR);
    faddr_sel = !ram_sel && !slv_any && !err_sel && (bus.cpu_addr == FADDR_ADDR);
    unmapped  = !(ram_sel || slv_any || err_sel || faddr_sel);
  end

  logic [DATA_W-1:0] slv_rd_mux;
  logic              sel_ready, slv_access;

  always_comb begin
    slv_rd_mux = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (slv_sel[i]) slv_rd_mux = bus.slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign sel_ready  = |(bus.slv_ready & slv_sel);
  assign slv_access = access & slv_any;

  assign bus.slv_addr  = bus.cpu_addr;
  assign bus.slv_wdata = bus.cpu_wdata;
  assign bus.slv_wr_en = slv_sel & {NUM_SLV{wr_acc}};
  assign bus.slv_rd_en = slv_sel & {NUM_SLV{rd_acc}};

  state_e state_q;
  logic   stall_raw, abort;

`ifdef FABRIC_TIMEOUT_EN
  localparam int unsigned WCNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [WCNT_W-1:0] wcnt_q;
`endif

  always_comb begin
    stall_raw = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      StIdle: stall_raw = slv_access & ~sel_ready;
      StWait: begin
        if (slv_access && !sel_ready) begin
`ifdef FABRIC_TIMEOUT_EN
          if (wcnt_q == WCNT_W'(TIMEOUT)) abort = 1'b1;
          else                            stall_raw = 1'b1;
`else
          stall_raw = 1'b1;
`endif
        end
      end
      default: stall_raw = 1'b0;
    endcase
  end

  // Reset forces stall low even while the CPU still holds an access.
  assign bus.cpu_stall = stall_raw & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
`ifdef FABRIC_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (slv_access && !sel_ready) begin
            state_q <= StWait;
`ifdef FABRIC_TIMEOUT_EN
            wcnt_q  <= WCNT_W'(1);
`endif
          end
        end
        StWait: begin
          if (!slv_access || sel_ready || abort) begin
            state_q <= StIdle;
          end
`ifdef FABRIC_TIMEOUT_EN
          else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Fault capture: clear is applied first so a same-cycle fault survives it.
  logic              unm_flag_q, unm_flag_d, to_flag, irq_q;
  logic [3:0]        ecnt_q, ecnt_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic              fault_ev, err_clr;

  assign fault_ev = (access & unmapped) | abort;
  assign err_clr  = bus.cpu_wr_en & err_sel;

  always_comb begin
    unm_flag_d = unm_flag_q & ~err_clr;
    if (access && unmapped) unm_flag_d = 1'b1;
    ecnt_d = err_clr ? 4'd0 : ecnt_q;
    if (fault_ev && (ecnt_d != 4'hF)) ecnt_d = ecnt_d + 4'd1;
    faddr_d = fault_ev ? bus.cpu_addr : faddr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unm_flag_q <= 1'b0;
      ecnt_q     <= '0;
      faddr_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      unm_flag_q <= unm_flag_d;
      ecnt_q     <= ecnt_d;
      faddr_q    <= faddr_d;
      irq_q      <= unm_flag_q | to_flag;
    end
  end

`ifdef FABRIC_TIMEOUT_EN
  logic to_flag_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_flag_q <= 1'b0;
    else          to_flag_q <= abort | (to_flag_q & ~err_clr);
  end
  assign to_flag = to_flag_q;
`else
  assign to_flag = 1'b0;
`endif

  assign bus_err_irq = irq_q;

  // Word 0 is a read-only mirror of the CPU status register.
  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  assign ram_idx = bus.cpu_addr[RAM_AW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q[0] <= bus.cpu_status;
      if (wr_acc && ram_sel && (ram_idx != '0)) mem_q[ram_idx] <= bus.cpu_wdata;
    end
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (ram_sel)        bus.cpu_rdata = mem_q[ram_idx];
    else if (slv_any)   bus.cpu_rdata = abort ? '1 : slv_rd_mux;
    else if (err_sel)   bus.cpu_rdata = DATA_W'({ecnt_q, 2'b00, to_flag, unm_flag_q});
    else if (faddr_sel) bus.cpu_rdata = DATA_W'(faddr_q);
  end

endmodule

// File: tb/tb_trsq_bus_fabric.sv
// Self-checking bench for trsq_bus_fabric: directed scenarios plus randomized traffic
// compared against an address-map level reference model.
module tb_trsq_bus_fabric;

  localparam int TO_CYC = 15;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic bus_err_irq;
  int   errors  = 0;
  int   checks  = 0;

  trsq_bus_fabric_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3)) bus ();

  trsq_bus_fabric #(
    .ADDR_W(8), .DATA_W(8), .RAM_DEPTH(128), .NUM_SLV(3), .SLV_SPAN_LOG2(2),
    .SLV_BASE({8'h90, 8'h84, 8'h80}), .ERR_ADDR(8'hFF), .TIMEOUT(TO_CYC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .bus_err_irq(bus_err_irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_ram [128];
  logic       m_unm, m_to, m_irq;
  logic [3:0] m_cnt;
  logic [7:0] m_faddr;
  logic [7:0] status_drv;
  int         slv_base [3] = '{8'h80, 8'h84, 8'h90};

  // 0 RAM, 1 slave, 2 error reg, 3 fault-address reg, 4 unmapped
  function automatic int kind_of(input logic [7:0] a, output int sidx);
    sidx = -1;
    if (int'(a) < 128) return 0;
    for (int i = 0; i < 3; i++) begin
      if (int'(a) >= slv_base[i] && int'(a) < slv_base[i] + 4) begin
        sidx = i;
        return 1;
      end
    end
    if (a == 8'hFF) return 2;
    if (a == 8'hFE) return 3;
    return 4;
  endfunction

  function automatic logic [7:0] m_err();
    return {m_cnt, 2'b00, m_to, m_unm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_ram[i] = 8'h00;
    m_unm = 0; m_to = 0; m_irq = 0; m_cnt = 0; m_faddr = 0;
  endtask

  task automatic model_fault(input logic [7:0] a, input logic is_to);
    if (is_to) m_to = 1'b1;
    else       m_unm = 1'b1;
    if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    m_faddr = a;
  endtask

  task automatic model_clear();
    m_unm = 0; m_to = 0; m_cnt = 0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic wr, input logic rd);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wr_en = wr;
    bus.cpu_rd_en = rd;
  endtask

  // One clock edge; irq follows the flags held before the edge.
  task automatic step();
    m_irq    = m_unm | m_to;
    m_ram[0] = status_drv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall);
    end
    checks++;
    if (bus_err_irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", bus_err_irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_ram[0] = status_drv;
    drive(8'h10, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_ram10: got %h want 00", bus.cpu_rdata);
    end
    step();
    drive(8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_errreg: got %h want 00", bus.cpu_rdata);
    end
    step();
    drive(8'hFE, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_faddr: got %h want 00", bus.cpu_rdata);
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_ram();
    logic [7:0] v;
    drive(8'h10, 8'h5A, 1'b1, 1'b0);
    step(); m_ram[8'h10] = 8'h5A;
    drive(8'h10, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_ram[8'h10] || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL ram_rd10: got %h/%b want %h/0", bus.cpu_rdata, bus.cpu_stall,
                         m_ram[8'h10]);
    end
    step();
    drive(8'h00, 8'h11, 1'b1, 1'b0);
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'hC3) begin
      errors++; $display("FAIL ram_status: got %h want c3", bus.cpu_rdata);
    end
    step();
    v = 8'($urandom_range(0, 255));
    drive(8'h7F, v, 1'b1, 1'b0);
    step(); m_ram[8'h7F] = v;
    drive(8'h7F, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_ram[8'h7F]) begin
      errors++; $display("FAIL ram_top: got %h want %h", bus.cpu_rdata, m_ram[8'h7F]);
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_slave_wait();
    bus.slv_rdata = {8'hAA, 8'h77, 8'h55};
    bus.slv_ready = 3'b101;
    drive(8'h85, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b1 || bus.slv_rd_en !== 3'b010) begin
        errors++; $display("FAIL wait_stall%0d: got %b/%b want 1/010", c, bus.cpu_stall,
                           bus.slv_rd_en);
      end
      step();
    end
    bus.slv_ready = 3'b010;
    @(negedge clk);
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 8'h77 || bus.slv_rd_en !== 3'b010) begin
      errors++; $display("FAIL wait_done: got %b/%h/%b want 0/77/010", bus.cpu_stall,
                         bus.cpu_rdata, bus.slv_rd_en);
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wr_rd_both();
    bus.slv_ready = 3'b111;
    drive(8'h81, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.slv_wr_en !== 3'b001 || bus.slv_rd_en !== 3'b000 || bus.cpu_stall !== 1'b0 ||
        bus.slv_addr !== 8'h81 || bus.slv_wdata !== 8'h3C) begin
      errors++; $display("FAIL both_strobes: got wr=%b rd=%b st=%b a=%h d=%h want 001 000 0 81 3c",
                         bus.slv_wr_en, bus.slv_rd_en, bus.cpu_stall, bus.slv_addr,
                         bus.slv_wdata);
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int hi;
    drive(8'hFF, 8'h00, 1'b1, 1'b0);
    step(); model_clear();
    bus.slv_ready = 3'b000;
    drive(8'h90, 8'h00, 1'b0, 1'b1);
`ifdef FABRIC_TIMEOUT_EN
    begin
      logic dropped;
      hi = 0;
      dropped = 1'b0;
      for (int c = 0; c < 30 && !dropped; c++) begin
        @(negedge clk);
        if (bus.cpu_stall === 1'b1) begin
          hi++;
          step();
        end else begin
          dropped = 1'b1;
          checks++;
          if (bus.cpu_rdata !== 8'hFF) begin
            errors++; $display("FAIL to_rdata: got %h want ff", bus.cpu_rdata);
          end
        end
      end
      checks++;
      if (!dropped || hi != TO_CYC) begin
        errors++; $display("FAIL to_stall_len: got %0d want %0d", hi, TO_CYC);
      end
      step(); model_fault(8'h90, 1'b1);
    end
`else
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.cpu_stall === 1'b1) hi++;
      step();
    end
    checks++;
    if (hi != 20) begin
      errors++; $display("FAIL hold_stall: got %0d want 20", hi);
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
`endif
    drive(8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_err() || bus_err_irq !== m_irq) begin
      errors++; $display("FAIL to_errreg: got %h/%b want %h/%b", bus.cpu_rdata, bus_err_irq,
                         m_err(), m_irq);
    end
    step();
    drive(8'hFE, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_faddr || bus_err_irq !== m_irq) begin
      errors++; $display("FAIL to_faddr: got %h/%b want %h/%b", bus.cpu_rdata, bus_err_irq,
                         m_faddr, m_irq);
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    drive(8'hFF, 8'h00, 1'b1, 1'b0);
    step(); model_clear();
    for (int k = 0; k < 17; k++) begin
      drive(8'hA0, 8'(k), 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b0) begin
        errors++; $display("FAIL unm_stall%0d: got %b want 0", k, bus.cpu_stall);
      end
      step(); model_fault(8'hA0, 1'b0);
    end
    drive(8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_err()) begin
      errors++; $display("FAIL unm_sat: got %h want %h", bus.cpu_rdata, m_err());
    end
    step();
    drive(8'hA0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL unm_rd: got %h want 00", bus.cpu_rdata);
    end
    step(); model_fault(8'hA0, 1'b0);
    drive(8'hFE, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_faddr) begin
      errors++; $display("FAIL unm_faddr: got %h want %h", bus.cpu_rdata, m_faddr);
    end
    step();
    drive(8'hFF, 8'h00, 1'b1, 1'b0);
    step(); model_clear();
    drive(8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_err() || bus_err_irq !== m_irq) begin
      errors++; $display("FAIL clr_errreg: got %h/%b want %h/%b", bus.cpu_rdata, bus_err_irq,
                         m_err(), m_irq);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus_err_irq !== m_irq) begin
      errors++; $display("FAIL clr_irq: got %b want %b", bus_err_irq, m_irq);
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      int         pick, kind, sidx, dly;
      logic [7:0] a, wd;
      logic       wr, rd;
      logic [2:0] rdy;
      logic [7:0] sd [3];
      pick = $urandom_range(0, 9);
      sidx = $urandom_range(0, 2);
      if (pick < 4)      a = 8'($urandom_range(0, 127));
      else if (pick < 7) a = 8'(slv_base[sidx] + $urandom_range(0, 3));
      else if (pick < 9) a = 8'($urandom_range(128, 253));
      else               a = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hFE;
      wr = 1'($urandom_range(0, 1));
      rd = !wr || ($urandom_range(0, 3) == 0);
      wd = 8'($urandom_range(0, 255));
      dly = $urandom_range(0, 4);
      kind = kind_of(a, sidx);
      if ($urandom_range(0, 7) == 0) status_drv = 8'($urandom_range(0, 255));
      bus.cpu_status = status_drv;
      for (int i = 0; i < 3; i++) sd[i] = 8'($urandom_range(0, 255));
      bus.slv_rdata = {sd[2], sd[1], sd[0]};
      rdy = 3'($urandom_range(0, 7));
      if (kind == 1) rdy[sidx] = (dly == 0);
      bus.slv_ready = rdy;
      drive(a, wd, wr, rd);
      @(negedge clk);
      checks++;
      if (bus_err_irq !== m_irq) begin
        errors++; $display("FAIL rnd_irq n=%0d: got %b want %b", n, bus_err_irq, m_irq);
      end
      if (kind == 1) begin
        for (int c = 0; c < dly; c++) begin
          checks++;
          if (bus.cpu_stall !== 1'b1) begin
            errors++; $display("FAIL rnd_wait n=%0d a=%h: got %b want 1", n, a, bus.cpu_stall);
          end
          step();
          rdy = 3'($urandom_range(0, 7));
          rdy[sidx] = (c == dly - 1);
          bus.slv_ready = rdy;
          @(negedge clk);
        end
        checks++;
        if (bus.cpu_stall !== 1'b0 ||
            bus.slv_wr_en !== (wr ? 3'(1 << sidx) : 3'b000) ||
            bus.slv_rd_en !== ((rd && !wr) ? 3'(1 << sidx) : 3'b000) ||
            ((rd && !wr) && bus.cpu_rdata !== sd[sidx])) begin
          errors++; $display("FAIL rnd_slv n=%0d a=%h: got st=%b wr=%b rd=%b d=%h want d=%h",
                             n, a, bus.cpu_stall, bus.slv_wr_en, bus.slv_rd_en, bus.cpu_rdata,
                             sd[sidx]);
        end
        step();
      end else begin
        logic [7:0] exp;
        case (kind)
          0:       exp = m_ram[a[6:0]];
          2:       exp = m_err();
          3:       exp = m_faddr;
          default: exp = 8'h00;
        endcase
        checks++;
        if (bus.cpu_stall !== 1'b0 || ((rd && !wr) && bus.cpu_rdata !== exp)) begin
          errors++; $display("FAIL rnd_acc n=%0d a=%h: got st=%b d=%h want st=0 d=%h", n, a,
                             bus.cpu_stall, bus.cpu_rdata, exp);
        end
        step();
        if (kind == 0 && wr && a != 8'h00) m_ram[a[6:0]] = wd;
        if (kind == 2 && wr) model_clear();
        if (kind == 4) model_fault(a, 1'b0);
      end
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    status_drv = 8'hC3;
    bus.cpu_status = status_drv;
    step();
  endtask

  task automatic test_reset_mid_wait();
    drive(8'h10, 8'h5A, 1'b1, 1'b0);
    step(); m_ram[8'h10] = 8'h5A;
    drive(8'hA4, 8'h00, 1'b1, 1'b0);
    step(); model_fault(8'hA4, 1'b0);
    bus.slv_ready = 3'b000;
    drive(8'h84, 8'h00, 1'b0, 1'b1);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus_err_irq !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: got stall=%b irq=%b want 0/0", bus.cpu_stall,
                         bus_err_irq);
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    m_ram[0] = status_drv;
    drive(8'h10, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_ram[8'h10]) begin
      errors++; $display("FAIL midwait_ram: got %h want %h", bus.cpu_rdata, m_ram[8'h10]);
    end
    step();
    drive(8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== m_err()) begin
      errors++; $display("FAIL midwait_err: got %h want %h", bus.cpu_rdata, m_err());
    end
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    status_drv     = 8'hC3;
    bus.cpu_status = status_drv;
    bus.slv_rdata  = '0;
    bus.slv_ready  = '0;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_ram();
    test_slave_wait();
    test_wr_rd_both();
    test_timeout();
    test_unmapped();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
